regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width of each entry.
REQ-002 The module SHALL have parameter NREGS, default 32, giving the entry count; the address width SHALL be 5 bits and NREGS SHALL be 32.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The module SHALL have port rd_addr1, input, 5, the read port 1 address.
REQ-006 The module SHALL have port rd_addr2, input, 5, the read port 2 address.
REQ-007 The module SHALL have port rd_data1, output, WIDTH, the combinational read data for port 1.
REQ-008 The module SHALL have port rd_data2, output, WIDTH, the combinational read data for port 2.
REQ-009 The module SHALL have port wr_en, input, 1, the write request.
REQ-010 The module SHALL have port wr_addr, input, 5, the write address.
REQ-011 The module SHALL have port wr_data, input, WIDTH, the write data.
REQ-012 The module SHALL have port clear_req, input, 1, a request to zero the whole file sequentially.
REQ-013 The module SHALL have port busy, output, 1, high while a clear is in progress.
REQ-014 The module SHALL have port wr_dropped, output, 1, a registered one-cycle pulse flagging a rejected write.

Function
REQ-015 Entry 0 SHALL always read as 0; writes to address 0 SHALL be discarded without setting wr_dropped.
REQ-016 Reads SHALL be combinational: rd_dataN = entry[rd_addrN], with no clock latency.
REQ-017 A write SHALL be accepted when wr_en=1, the FSM is in IDLE and clear_req=0.
REQ-018 An accepted write SHALL update entry[wr_addr] at the clock edge, and the new value SHALL be visible on the read ports from the next cycle.
REQ-019 The FSM SHALL have two states, IDLE and CLEAR.
REQ-020 In IDLE with clear_req=1, the next state SHALL be CLEAR and the 5-bit clear counter SHALL be loaded with 1.
REQ-021 In CLEAR, each edge SHALL zero entry[cnt] and increment cnt; when cnt=31, entry 31 SHALL be zeroed and the FSM SHALL return to IDLE, so a clear takes 31 cycles.
REQ-022 busy SHALL be 1 exactly while the state is CLEAR; busy is registered and rises on the edge that accepts clear_req.
REQ-023 A write with wr_en=1 and wr_addr!=0 SHALL be rejected while busy=1, or when clear_req=1 in the same cycle (clear wins); on rejection wr_dropped=1 on the next cycle and no entry changes.
REQ-024 clear_req SHALL be ignored while in CLEAR; clear_req held high at completion SHALL start a new clear after one IDLE cycle.
REQ-025 During CLEAR, reads SHALL return 0 for entries already cleared and the old value for entries not yet cleared.

Reset
REQ-026 When reset=1 at a rising edge, all entries SHALL become 0, state SHALL become IDLE, cnt SHALL become 0, and busy and wr_dropped SHALL become 0.
REQ-027 Reset SHALL take priority over wr_en and clear_req, and SHALL abort a clear in progress.
REQ-028 There SHALL be no asynchronous reset path.

Configuration
REQ-029 The macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 When REGFILE_BYPASS_EN is defined, if a write is accepted this cycle and rd_addrN equals wr_addr and is nonzero, rd_dataN SHALL equal wr_data combinationally.
REQ-031 When REGFILE_BYPASS_EN is defined, rejected writes SHALL never be forwarded.
REQ-032 When REGFILE_BYPASS_EN is not defined, reads SHALL return the stored value (the old value during a same-cycle write) and no forwarding logic SHALL exist.

Verification
REQ-033 The bench SHALL cover: reset, then write 0xDEADBEEF to reg 5 -> next cycle rd_data1 (addr 5) = 0xDEADBEEF, and rd_data2 (addr 0) = 0.
REQ-034 The bench SHALL cover: write 0x12345678 to reg 0 -> reg 0 reads 0 and wr_dropped stays 0.
REQ-035 The bench SHALL cover: fill regs 1..31 with their index, pulse clear_req for 1 cycle -> busy high for 31 cycles; reg 10 reads 0 after 10 busy cycles while reg 20 still reads 20; all regs read 0 after busy falls.
REQ-036 The bench SHALL cover: wr_en to reg 3 during busy, and wr_en coincident with clear_req -> wr_dropped=1 for one cycle each, and reg 3 is unchanged by the rejected write.
REQ-037 The bench SHALL cover: reset asserted at cycle 15 of a clear -> busy=0 next cycle, all regs read 0, and a following write to reg 7 is accepted.
REQ-038 The bench SHALL cover: same-cycle write 0xA5A5A5A5 to reg 9 while reading reg 9 (old value 0x1) -> read returns 0xA5A5A5A5 with REGFILE_BYPASS_EN and 0x1 without it.

Source files
------------

// File: rtl/regfile.sv
// regfile: 32-entry register file with two combinational read ports, one write port and a sequential clear.
// Define REGFILE_BYPASS_EN to forward an accepted same-cycle write onto matching read ports.
module regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rd_addr1,
    input  logic [4:0]       rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clear_req,
    output logic             busy,
    output logic             wr_dropped
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             wr_dropped_q, wr_dropped_d;
    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];
    logic             wr_acc;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_dropped_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_dropped_q <= wr_dropped_d;
            mem_q        <= mem_d;
        end
    end
    // A pending clear request always wins over a write in the same cycle.
    always_comb begin
        wr_acc       = wr_en && state_q == IDLE && !clear_req && wr_addr != 5'd0;
        wr_dropped_d = wr_en && wr_addr != 5'd0 && (state_q == CLEAR || clear_req);
        state_d      = state_q == IDLE ? (clear_req ? CLEAR : IDLE) : (cnt_q == 5'd31 ? IDLE : CLEAR);
        cnt_d        = state_q == CLEAR ? cnt_q + 5'd1 : (clear_req ? 5'd1 : cnt_q);
        mem_d        = mem_q;
        if (state_q == CLEAR)
            mem_d[cnt_q] = '0;
        else if (wr_acc)
            mem_d[wr_addr] = wr_data;
    end
    always_comb begin
        busy       = state_q == CLEAR;
        wr_dropped = wr_dropped_q;
`ifdef REGFILE_BYPASS_EN
        rd_data1   = (wr_acc && rd_addr1 == wr_addr) ? wr_data : mem_q[rd_addr1];
        rd_data2   = (wr_acc && rd_addr2 == wr_addr) ? wr_data : mem_q[rd_addr2];
`else
        rd_data1   = mem_q[rd_addr1];
        rd_data2   = mem_q[rd_addr2];
`endif
    end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed plus randomized checks of regfile against an array-based reference model.
module tb_regfile;
    logic        clk = 1'b0;
    logic        reset, wr_en, clear_req, busy, wr_dropped;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr;
    logic [31:0] wr_data, rd_data1, rd_data2;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m [32];
    bit          mbusy = 1'b0;
    bit          mdrop = 1'b0;
    int          mk = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .busy(busy), .wr_dropped(wr_dropped)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (!mbusy && !clear_req && wr_en && wr_addr != 5'd0 && a == wr_addr) return wr_data;
`endif
        return m[a];
    endfunction

    task automatic drv(input bit r, input bit c, input bit w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        reset = r; clear_req = c; wr_en = w; wr_addr = wa; wr_data = wd;
        rd_addr1 = a1; rd_addr2 = a2;
        #1;
        if (!r) begin
            chk($sformatf("rd1[%0d]", a1), rd_data1, exp_rd(a1));
            chk($sformatf("rd2[%0d]", a2), rd_data2, exp_rd(a2));
        end
    endtask

    task automatic tick();
        bit acc;
        acc   = !mbusy && !clear_req && wr_en && wr_addr != 5'd0;
        mdrop = !reset && wr_en && wr_addr != 5'd0 && (mbusy || clear_req);
        if (reset) begin
            foreach (m[i]) m[i] = '0;
            mbusy = 1'b0;
        end else if (mbusy) begin
            m[mk] = '0;
            mk++;
            if (mk == 32) mbusy = 1'b0;
        end else if (clear_req) begin
            mbusy = 1'b1;
            mk = 1;
        end else if (acc) begin
            m[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
        chk("busy", {31'b0, busy}, {31'b0, mbusy});
        chk("wr_dropped", {31'b0, wr_dropped}, {31'b0, mdrop});
    endtask

    task automatic cyc(input bit r, input bit c, input bit w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        drv(r, c, w, wa, wd, a1, a2);
        tick();
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i += 2) cyc(0, 0, 0, 5'd0, 32'd0, 5'(i), 5'(i + 1));
    endtask

    initial begin
        foreach (m[i]) m[i] = '0;
        drv(1, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        read_all();
        // single write, read back on the next cycle
        cyc(0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        drv(0, 0, 0, 5'd0, 32'd0, 5'd5, 5'd0);
        chk("r5_value", rd_data1, 32'hDEADBEEF);
        chk("r0_zero", rd_data2, 32'd0);
        tick();
        // writes to entry 0 vanish quietly
        cyc(0, 0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        drv(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd5);
        chk("r0_after_write", rd_data1, 32'd0);
        chk("r0_no_drop", {31'b0, wr_dropped}, 32'd0);
        tick();
        // fill with index, then a one-cycle clear pulse
        for (int i = 1; i < 32; i++) cyc(0, 0, 1, 5'(i), 32'(i), 5'd0, 5'd0);
        cyc(0, 1, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 1; i <= 31; i++) begin
            drv(0, 0, 0, 5'd0, 32'd0, 5'd10, 5'd20);
            chk("busy_during_clear", {31'b0, busy}, 32'd1);
            if (i == 11) begin
                chk("r10_cleared", rd_data1, 32'd0);
                chk("r20_not_yet", rd_data2, 32'd20);
            end
            tick();
        end
        chk("busy_fell", {31'b0, busy}, 32'd0);
        read_all();
        // random writes and reads
        repeat (60) cyc(0, 0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        // rejected writes: coincident with clear_req, then while busy
        cyc(0, 0, 1, 5'd3, 32'h33, 5'd0, 5'd0);
        cyc(0, 1, 1, 5'd3, 32'hBAD0BAD0, 5'd3, 5'd0);
        chk("drop_coincident", {31'b0, wr_dropped}, 32'd1);
        cyc(0, 0, 1, 5'd3, 32'hBAD1BAD1, 5'd3, 5'd0);
        chk("drop_busy", {31'b0, wr_dropped}, 32'd1);
        drv(0, 0, 0, 5'd0, 32'd0, 5'd3, 5'd0);
        chk("r3_kept", rd_data1, 32'h33);
        tick();
        chk("drop_one_cycle", {31'b0, wr_dropped}, 32'd0);
        // reset in the 15th busy cycle aborts the clear
        for (int i = 3; i < 15; i++) cyc(0, 0, 0, 5'd0, 32'd0, 5'(i), 5'(i + 16));
        cyc(1, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("busy_aborted", {31'b0, busy}, 32'd0);
        read_all();
        cyc(0, 0, 1, 5'd7, 32'h77770007, 5'd0, 5'd0);
        drv(0, 0, 0, 5'd0, 32'd0, 5'd7, 5'd0);
        chk("r7_after_reset", rd_data1, 32'h77770007);
        tick();
        // same-cycle write and read of one entry
        cyc(0, 0, 1, 5'd9, 32'h1, 5'd0, 5'd0);
        drv(0, 0, 1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
        chk("r9_same_cycle", rd_data1, 32'hA5A5A5A5);
`else
        chk("r9_same_cycle", rd_data1, 32'h1);
`endif
        tick();
        drv(0, 0, 0, 5'd0, 32'd0, 5'd9, 5'd0);
        chk("r9_next_cycle", rd_data1, 32'hA5A5A5A5);
        tick();
        // clear_req held high: back-to-back clears with one idle cycle between
        repeat (70) cyc(0, 1, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        cyc(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        // mixed random traffic with occasional clears and resets
        repeat (300) cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0),
                         1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
